// File: rtl/multicycle_control.sv
// Multi-cycle DLX control: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables and selects.
// FETCH and MEM stall on mem_ready; mult holds EXEC for MULT_CYCLES cycles; outputs are combinational from registers.
module multicycle_control #(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opc,
    input  logic [5:0] func,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src,
    output logic [3:0] alu_op,
    output logic       cond,
    output logic [2:0] cond_op,
    output logic       ext_op,
    output logic [1:0] dsize,
    output logic       dext_op,
    output logic       lhi,
    output logic       mult_start,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
    typedef enum logic [3:0] {
        C_NOP, C_ALU, C_SET, C_LHI, C_LOAD, C_STORE, C_BEQZ, C_BNEZ,
        C_J, C_JR, C_JAL, C_JALR, C_MULT
    } cls_t;

    state_t           cur, nxt;
    cls_t             cls_q, d_cls;
    logic             rtype_q, ext_q, dext_q, illegal_q, exec_first;
    logic [3:0]       alu_op_q, d_alu;
    logic [2:0]       cond_op_q, d_cond;
    logic [1:0]       dsize_q, d_dsize;
    logic             d_ext, d_dext, d_bad;
    logic [CNT_W-1:0] cnt;

    // Set-class ops share the same ordering in func[2:0] (R-type) and opc[2:0] (immediate).
    function automatic logic [2:0] set_code(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b000;
            3'd1:    return 3'b001;
            3'd2:    return 3'b011;
            3'd3:    return 3'b101;
            3'd4:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    always_comb begin
        d_cls   = C_NOP;
        d_alu   = 4'b0000;
        d_cond  = 3'b000;
        d_ext   = 1'b1;
        d_dsize = 2'b00;
        d_dext  = 1'b1;
        d_bad   = 1'b0;
        case (opc)
            6'h00: case (func)
                6'h04:        begin d_cls = C_ALU; d_alu = 4'b1000; end
                6'h06:        begin d_cls = C_ALU; d_alu = 4'b1001; end
                6'h07:        begin d_cls = C_ALU; d_alu = 4'b1010; end
                6'h20, 6'h21: d_cls = C_ALU;
                6'h22, 6'h23: begin d_cls = C_ALU; d_alu = 4'b0001; end
                6'h24:        begin d_cls = C_ALU; d_alu = 4'b0100; end
                6'h25:        begin d_cls = C_ALU; d_alu = 4'b0101; end
                6'h26:        begin d_cls = C_ALU; d_alu = 4'b0110; end
                6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D: begin
                    d_cls = C_SET; d_alu = 4'b0001; d_cond = set_code(func[2:0]);
                end
                6'h0E, 6'h16: d_cls = C_MULT;
                6'h15:        d_cls = C_NOP;
                default:      d_bad = 1'b1;
            endcase
            6'h02: d_cls = C_J;
            6'h03: d_cls = C_JAL;
            6'h04: d_cls = C_BEQZ;
            6'h05: d_cls = C_BNEZ;
            6'h12: d_cls = C_JR;
            6'h13: d_cls = C_JALR;
            6'h08: d_cls = C_ALU;
            6'h09: begin d_cls = C_ALU; d_ext = 1'b0; end
            6'h0A: begin d_cls = C_ALU; d_alu = 4'b0001; end
            6'h0B: begin d_cls = C_ALU; d_alu = 4'b0001; d_ext = 1'b0; end
            6'h0C: begin d_cls = C_ALU; d_alu = 4'b0100; end
            6'h0D: begin d_cls = C_ALU; d_alu = 4'b0101; end
            6'h0E: begin d_cls = C_ALU; d_alu = 4'b0110; end
            6'h0F: d_cls = C_LHI;
            6'h14: begin d_cls = C_ALU; d_alu = 4'b1000; end
            6'h16: begin d_cls = C_ALU; d_alu = 4'b1001; end
            6'h17: begin d_cls = C_ALU; d_alu = 4'b1010; end
            6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: begin
                d_cls = C_SET; d_alu = 4'b0001; d_cond = set_code(opc[2:0]);
            end
            6'h20: d_cls = C_LOAD;
            6'h21: begin d_cls = C_LOAD; d_dsize = 2'b01; end
            6'h23: begin d_cls = C_LOAD; d_dsize = 2'b11; end
            6'h24: begin d_cls = C_LOAD; d_dext = 1'b0; end
            6'h25: begin d_cls = C_LOAD; d_dsize = 2'b01; d_dext = 1'b0; end
            6'h28: d_cls = C_STORE;
            6'h29: begin d_cls = C_STORE; d_dsize = 2'b01; end
            6'h2B: begin d_cls = C_STORE; d_dsize = 2'b11; end
            default: d_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= FETCH;
            cls_q      <= C_NOP;
            rtype_q    <= 1'b0;
            alu_op_q   <= 4'b0000;
            cond_op_q  <= 3'b000;
            ext_q      <= 1'b0;
            dsize_q    <= 2'b00;
            dext_q     <= 1'b0;
            illegal_q  <= 1'b0;
            cnt        <= '0;
            exec_first <= 1'b0;
        end else begin
            cur        <= nxt;
            exec_first <= (cur == DECODE);
            if (cur == DECODE) begin
                cls_q     <= d_cls;
                rtype_q   <= (opc == 6'h00);
                alu_op_q  <= d_alu;
                cond_op_q <= d_cond;
                ext_q     <= d_ext;
                dsize_q   <= d_dsize;
                dext_q    <= d_dext;
                cnt       <= CNT_W'(MULT_CYCLES - 1);
                if (d_bad) illegal_q <= 1'b1;
            end else if (cur == EXEC && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        nxt        = cur;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src    = 1'b0;
        mult_start = 1'b0;
        alu_op     = alu_op_q;
        cond_op    = cond_op_q;
        ext_op     = ext_q;
        dsize      = dsize_q;
        dext_op    = dext_q;
        illegal    = illegal_q;
        state      = cur;
        cond       = (cur == EXEC || cur == WB) && cls_q == C_SET;
        lhi        = (cur == EXEC || cur == WB) && cls_q == C_LHI;
        case (cur)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end
            end
            DECODE: nxt = d_bad ? FETCH : EXEC;
            EXEC: case (cls_q)
                C_ALU, C_SET, C_LHI: begin alu_src = ~rtype_q; nxt = WB; end
                C_LOAD, C_STORE:     begin alu_src = 1'b1; nxt = MEM; end
                C_BEQZ: begin pc_write = alu_zero;  pc_src = 2'b01; nxt = FETCH; end
                C_BNEZ: begin pc_write = ~alu_zero; pc_src = 2'b01; nxt = FETCH; end
                C_J:    begin pc_write = 1'b1; pc_src = 2'b10; nxt = FETCH; end
                C_JR:   begin pc_write = 1'b1; pc_src = 2'b11; nxt = FETCH; end
                C_JAL, C_JALR: begin
                    pc_write   = 1'b1;
                    pc_src     = (cls_q == C_JAL) ? 2'b10 : 2'b11;
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                    nxt        = FETCH;
                end
                C_MULT: begin
                    mult_start = exec_first;
                    if (cnt == '0) nxt = WB;
                end
                default: nxt = FETCH;
            endcase
            MEM: begin
                mem_read  = (cls_q == C_LOAD);
                mem_write = (cls_q == C_STORE);
                iord      = 1'b1;
                if (mem_ready) nxt = (cls_q == C_LOAD) ? WB : FETCH;
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = rtype_q ? 2'b01 : 2'b00;
                mem_to_reg = (cls_q == C_LOAD) ? 2'b01 : (cls_q == C_MULT) ? 2'b11 : 2'b00;
                nxt        = FETCH;
            end
            default: nxt = FETCH;
        endcase
        if (reset) begin
            nxt        = FETCH;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            alu_src    = 1'b0;
            mult_start = 1'b0;
            alu_op     = 4'b0000;
            cond_op    = 3'b000;
            ext_op     = 1'b0;
            dsize      = 2'b00;
            dext_op    = 1'b0;
            illegal    = 1'b0;
            state      = 3'd0;
            cond       = 1'b0;
            lhi        = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand sequences, and randomized run against a schedule model.
module tb_multicycle_control;
    localparam int MC = 4;
    localparam int K_ILL = 0, K_NOP = 1, K_ALU = 2, K_SET = 3, K_LHI = 4, K_LOAD = 5, K_STORE = 6,
                   K_BEQZ = 7, K_BNEZ = 8, K_J = 9, K_JR = 10, K_JAL = 11, K_JALR = 12, K_MULT = 13;
    localparam logic [5:0] E_IR = 6'b100000, E_PC = 6'b010000, E_MR = 6'b001000,
                           E_MW = 6'b000100, E_RW = 6'b000010, E_MS = 6'b000001;

    logic clk = 1'b0, reset, alu_zero, mem_ready;
    logic [5:0] opc, func;
    logic ir_write, pc_write, mem_read, mem_write, iord, reg_write, alu_src, cond, ext_op;
    logic dext_op, lhi, mult_start, illegal;
    logic [1:0] pc_src, reg_dst, mem_to_reg, dsize;
    logic [3:0] alu_op;
    logic [2:0] cond_op, state;

    multicycle_control #(.MULT_CYCLES(MC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opc(opc), .func(func), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_read(mem_read),
        .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .cond(cond), .cond_op(cond_op),
        .ext_op(ext_op), .dsize(dsize), .dext_op(dext_op), .lhi(lhi), .mult_start(mult_start),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {int cls; logic rtype; logic [3:0] aop; logic [2:0] cop; logic ext; logic [1:0] ds; logic dext;} ref_t;
    typedef struct {logic [2:0] st; logic mr; logic ill; logic [5:0] en; int kind; logic [10:0] aux;} cyc_t;
    typedef struct {logic [5:0] o; logic [5:0] f; logic az; int mw; int cyc; int regw; int pcw; logic [13:0] cap;} vec_t;

    int total = 0, bad = 0;
    cyc_t sched[$];
    logic m_ill;
    vec_t vt[14];
    logic [11:0] pool[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {ir_write, pc_write, pc_src, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
                alu_src, alu_op, cond, cond_op, ext_op, dsize, dext_op, lhi, mult_start, illegal, state};
    endfunction

    function automatic logic [2:0] scode(input int i);
        case (i)
            0: return 3'b000;  1: return 3'b001;  2: return 3'b011;
            3: return 3'b101;  4: return 3'b010;  default: return 3'b100;
        endcase
    endfunction

    // Reference decode of the DLX encoding table.
    function automatic ref_t dec(input logic [5:0] o, input logic [5:0] f);
        ref_t r;
        r.cls = K_ILL; r.rtype = (o == 6'h00); r.aop = 4'b0000; r.cop = 3'b000;
        r.ext = 1'b1; r.ds = 2'b00; r.dext = 1'b1;
        if (o == 6'h00) begin
            if (f == 6'h15) r.cls = K_NOP;
            else if (f == 6'h0E || f == 6'h16) r.cls = K_MULT;
            else if (f >= 6'h28 && f <= 6'h2D) begin r.cls = K_SET; r.aop = 4'b0001; r.cop = scode(int'(f) - 'h28); end
            else if (f == 6'h04) begin r.cls = K_ALU; r.aop = 4'b1000; end
            else if (f == 6'h06) begin r.cls = K_ALU; r.aop = 4'b1001; end
            else if (f == 6'h07) begin r.cls = K_ALU; r.aop = 4'b1010; end
            else if (f == 6'h20 || f == 6'h21) r.cls = K_ALU;
            else if (f == 6'h22 || f == 6'h23) begin r.cls = K_ALU; r.aop = 4'b0001; end
            else if (f == 6'h24) begin r.cls = K_ALU; r.aop = 4'b0100; end
            else if (f == 6'h25) begin r.cls = K_ALU; r.aop = 4'b0101; end
            else if (f == 6'h26) begin r.cls = K_ALU; r.aop = 4'b0110; end
        end else begin
            case (o)
                6'h02: r.cls = K_J;     6'h03: r.cls = K_JAL;
                6'h04: r.cls = K_BEQZ;  6'h05: r.cls = K_BNEZ;
                6'h12: r.cls = K_JR;    6'h13: r.cls = K_JALR;
                6'h0F: r.cls = K_LHI;
                6'h08, 6'h09: begin r.cls = K_ALU; r.ext = (o == 6'h08); end
                6'h0A, 6'h0B: begin r.cls = K_ALU; r.aop = 4'b0001; r.ext = (o == 6'h0A); end
                6'h0C: begin r.cls = K_ALU; r.aop = 4'b0100; end
                6'h0D: begin r.cls = K_ALU; r.aop = 4'b0101; end
                6'h0E: begin r.cls = K_ALU; r.aop = 4'b0110; end
                6'h14: begin r.cls = K_ALU; r.aop = 4'b1000; end
                6'h16: begin r.cls = K_ALU; r.aop = 4'b1001; end
                6'h17: begin r.cls = K_ALU; r.aop = 4'b1010; end
                6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: begin r.cls = K_SET; r.aop = 4'b0001; r.cop = scode(int'(o) - 'h18); end
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                    r.cls = K_LOAD; r.dext = !(o == 6'h24 || o == 6'h25);
                    r.ds = (o == 6'h23) ? 2'b11 : (o == 6'h21 || o == 6'h25) ? 2'b01 : 2'b00;
                end
                6'h28, 6'h29, 6'h2B: begin
                    r.cls = K_STORE; r.ds = (o == 6'h2B) ? 2'b11 : (o == 6'h29) ? 2'b01 : 2'b00;
                end
                default: r.cls = K_ILL;
            endcase
        end
        return r;
    endfunction

    function automatic logic [10:0] aux_of(input int k);
        case (k)
            1: return 11'({alu_src, alu_op, cond, cond_op, lhi, ext_op});
            2: return 11'({iord, dsize, dext_op});
            3: return 11'({reg_dst, mem_to_reg});
            4: return 11'({reg_dst, mem_to_reg, pc_src});
            5: return 11'(pc_src);
            6: return 11'({alu_src, alu_op});
            default: return 11'd0;
        endcase
    endfunction

    task automatic push(input logic [2:0] st, input logic mr, input logic [5:0] en, input int kind, input logic [10:0] aux);
        cyc_t c;
        c.st = st; c.mr = mr; c.ill = m_ill; c.en = en; c.kind = kind; c.aux = aux;
        sched.push_back(c);
    endtask

    // Expected cycle-by-cycle timeline of one instruction, derived from the per-class CPI rules.
    task automatic build(input logic [5:0] o, input logic [5:0] f, input logic az, input int fw, input int mw);
        ref_t d;
        logic [1:0] wdst;
        d = dec(o, f);
        wdst = d.rtype ? 2'b01 : 2'b00;
        for (int i = 0; i < fw; i++) push(3'd0, 1'b0, E_MR, 0, 11'd0);
        push(3'd0, 1'b1, E_IR | E_PC | E_MR, 0, 11'd0);
        push(3'd1, 1'($urandom), 6'd0, 0, 11'd0);
        if (d.cls == K_ILL) m_ill = 1'b1;
        case (d.cls)
            K_ALU, K_SET, K_LHI: begin
                push(3'd2, 1'($urandom), 6'd0, 1, 11'({~d.rtype, d.aop, d.cls == K_SET, d.cop, d.cls == K_LHI, d.ext}));
                push(3'd4, 1'($urandom), E_RW, 3, 11'({wdst, 2'b00}));
            end
            K_LOAD, K_STORE: begin
                push(3'd2, 1'($urandom), 6'd0, 6, 11'({1'b1, 4'b0000}));
                for (int i = 0; i <= mw; i++)
                    push(3'd3, i == mw, (d.cls == K_LOAD) ? E_MR : E_MW, 2, 11'({1'b1, d.ds, d.dext}));
                if (d.cls == K_LOAD) push(3'd4, 1'($urandom), E_RW, 3, 11'({2'b00, 2'b01}));
            end
            K_BEQZ: push(3'd2, 1'($urandom), az ? E_PC : 6'd0, 5, 11'(2'b01));
            K_BNEZ: push(3'd2, 1'($urandom), az ? 6'd0 : E_PC, 5, 11'(2'b01));
            K_J:    push(3'd2, 1'($urandom), E_PC, 5, 11'(2'b10));
            K_JR:   push(3'd2, 1'($urandom), E_PC, 5, 11'(2'b11));
            K_JAL:  push(3'd2, 1'($urandom), E_PC | E_RW, 4, 11'({2'b10, 2'b10, 2'b10}));
            K_JALR: push(3'd2, 1'($urandom), E_PC | E_RW, 4, 11'({2'b10, 2'b10, 2'b11}));
            K_MULT: begin
                for (int i = 0; i < MC; i++) push(3'd2, 1'($urandom), (i == 0) ? E_MS : 6'd0, 0, 11'd0);
                push(3'd4, 1'($urandom), E_RW, 3, 11'({wdst, 2'b11}));
            end
            K_NOP:  push(3'd2, 1'($urandom), 6'd0, 0, 11'd0);
            default: ;
        endcase
    endtask

    task automatic apply(input logic [5:0] o, input logic [5:0] f, input logic az);
        cyc_t c;
        while (sched.size() > 0) begin
            c = sched.pop_front();
            mem_ready = c.mr;
            alu_zero = az;
            if (c.st <= 3'd1) begin opc = o; func = f; end
            else begin opc = 6'($urandom); func = 6'($urandom); end
            @(negedge clk);
            chk("rand_cycle", 32'({state, illegal, ir_write, pc_write, mem_read, mem_write, reg_write, mult_start}),
                32'({c.st, c.ill, c.en}));
            if (c.kind != 0) chk("rand_aux", 32'(aux_of(c.kind)), 32'(c.aux));
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH until FETCH comes round again, stalling MEM for mw cycles.
    task automatic run_measured(input logic [5:0] o, input logic [5:0] f, input logic az, input int mw,
                                output int cyc, output int rw, output int pw, output logic [13:0] cap);
        int w;
        w = 0; cyc = 0; rw = 0; pw = 0; cap = '0;
        opc = o; func = f; alu_zero = az;
        for (int n = 0; n < 200; n++) begin
            mem_ready = (state == 3'd3) ? (w >= mw) : 1'b1;
            @(negedge clk);
            if (reg_write) begin rw++; cap = {reg_dst, mem_to_reg, alu_op, cond, cond_op, dsize}; end
            if (pc_write) pw++;
            if (state == 3'd3) w++;
            @(posedge clk); #1;
            cyc++;
            if (state == 3'd0) break;
        end
    endtask

    initial begin
        int cyc, rw, pw, ms, ex, n;
        logic [13:0] cap;
        logic [1:0] m2r;
        logic [5:0] o, f;
        logic az;

        vt[0]  = '{6'h00, 6'h20, 1'b0, 0, 4, 1, 1, 14'b01_00_0000_0_000_00};
        vt[1]  = '{6'h23, 6'h00, 1'b0, 2, 7, 1, 1, 14'b00_01_0000_0_000_11};
        vt[2]  = '{6'h04, 6'h00, 1'b1, 0, 3, 0, 2, 14'd0};
        vt[3]  = '{6'h05, 6'h00, 1'b1, 0, 3, 0, 1, 14'd0};
        vt[4]  = '{6'h2B, 6'h00, 1'b0, 0, 4, 0, 1, 14'd0};
        vt[5]  = '{6'h00, 6'h0E, 1'b0, 0, 7, 1, 1, 14'b01_11_0000_0_000_00};
        vt[6]  = '{6'h1D, 6'h00, 1'b0, 0, 4, 1, 1, 14'b00_00_0001_1_100_00};
        vt[7]  = '{6'h03, 6'h00, 1'b0, 0, 3, 1, 2, 14'b10_10_0000_0_000_00};
        vt[8]  = '{6'h02, 6'h00, 1'b0, 0, 3, 0, 2, 14'd0};
        vt[9]  = '{6'h00, 6'h15, 1'b0, 0, 3, 0, 1, 14'd0};
        vt[10] = '{6'h25, 6'h00, 1'b0, 0, 5, 1, 1, 14'b00_01_0000_0_000_01};
        vt[11] = '{6'h0E, 6'h00, 1'b0, 0, 4, 1, 1, 14'b00_00_0110_0_000_00};
        vt[12] = '{6'h00, 6'h07, 1'b0, 0, 4, 1, 1, 14'b01_00_1010_0_000_00};
        vt[13] = '{6'h13, 6'h00, 1'b0, 0, 3, 1, 2, 14'b10_10_0000_0_000_00};
        pool = '{12'h020, 12'h022, 12'h025, 12'h004, 12'h02A, 12'h02D, 12'h00E, 12'h016,
                 12'h015, 12'h200, 12'h240, 12'h2C0, 12'h3C0, 12'h680, 12'h740, 12'h080,
                 12'h0C0, 12'h100, 12'h140, 12'h480, 12'h4C0, 12'h8C0, 12'h900, 12'hAC0};

        reset = 1'b1; opc = '0; func = '0; alu_zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_outputs", all_out(), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("post_reset_fetch", 32'({state, mem_read, iord, ir_write}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_measured(vt[i].o, vt[i].f, vt[i].az, vt[i].mw, cyc, rw, pw, cap);
            chk($sformatf("vec%0d_cycles", i), cyc, vt[i].cyc);
            chk($sformatf("vec%0d_regw", i), rw, vt[i].regw);
            chk($sformatf("vec%0d_pcw", i), pw, vt[i].pcw);
            if (vt[i].regw > 0) chk($sformatf("vec%0d_fields", i), 32'(cap), 32'(vt[i].cap));
        end

        // Reset while an lw is stalled in MEM.
        do_reset();
        opc = 6'h23; func = 6'h00; mem_ready = 1'b1; n = 0;
        while (state != 3'd3 && n < 10) begin @(posedge clk); #1; n++; end
        mem_ready = 1'b0;
        chk("reach_mem", 32'(state), 32'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_in_mem_outputs", all_out(), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_mem_reset", 32'({state, mem_read, mem_write, reg_write}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));
        @(posedge clk); #1;

        // mult: one start pulse, EXEC held MC cycles, WB selects the multiplier.
        do_reset();
        opc = 6'h00; func = 6'h0E; alu_zero = 1'b0; mem_ready = 1'b1;
        ms = 0; ex = 0; m2r = 2'b00;
        for (int i = 0; i < 3 + MC; i++) begin
            @(negedge clk);
            if (mult_start) ms++;
            if (state == 3'd2) ex++;
            if (state == 3'd4) m2r = mem_to_reg;
            @(posedge clk); #1;
        end
        chk("mult_start_pulses", ms, 1);
        chk("mult_exec_cycles", ex, MC);
        chk("mult_wb_sel", 32'(m2r), 32'd3);

        // Illegal encoding is sticky across a following legal instruction.
        do_reset();
        run_measured(6'h3F, 6'h00, 1'b0, 0, cyc, rw, pw, cap);
        chk("illegal_cycles", cyc, 2);
        chk("illegal_set", 32'(illegal), 32'd1);
        run_measured(6'h1D, 6'h00, 1'b0, 0, cyc, rw, pw, cap);
        chk("sgei_after_illegal_cycles", cyc, 4);
        chk("sgei_after_illegal_fields", 32'({rw, cap}), 32'({32'd1, 14'b00_00_0001_1_100_00}));
        chk("illegal_sticky", 32'(illegal), 32'd1);

        do_reset();
        m_ill = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin o = 6'($urandom); f = 6'($urandom); end
            else begin
                {o, f} = pool[$urandom_range(0, 23)];
                if (o != 6'h00) f = 6'($urandom);
            end
            az = 1'($urandom);
            build(o, f, az, $urandom_range(0, 2), $urandom_range(0, 2));
            apply(o, f, az);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
